// File: rtl/gene_bus_serializer.sv
// Multi-write / single-read circular FIFO that turns a packed multi-gene batch into a one-gene-per-cycle stream.
// Optional per-genome pop counter is built when GENE_SER_CNT_EN is defined; otherwise out_gene_cnt is tied to 0.
module gene_bus_serializer #(
    parameter int GENE_SZ = 64,
    parameter int LANES   = 6,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [LANES*GENE_SZ-1:0] in_bus,
    input  logic [2:0]               in_cnt,
    input  logic                     in_eog,
    output logic                     in_ready,
    output logic [GENE_SZ-1:0]       out_gene,
    output logic                     out_valid,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     err,
    output logic [15:0]              out_gene_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [GENE_SZ-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]   tag_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [CW-1:0] free;
    logic [CW-1:0] cnt_w;
    logic          batch_nz;
    logic          batch_bad;
    logic          push;
    logic          drop;
    logic          pop;

    // free is taken from the pre-cycle count, so a same-cycle pop never makes room for a push
    assign free      = CW'(DEPTH) - count_q;
    assign cnt_w     = CW'(in_cnt);
    assign batch_nz  = (in_cnt != 3'd0);
    assign batch_bad = (int'(in_cnt) > LANES);
    assign push      = !clr && batch_nz && !batch_bad && (free >= cnt_w);
    assign drop      = !clr && batch_nz && (batch_bad || (free < cnt_w));
    assign pop       = !clr && out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(in_cnt);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + (push ? cnt_w : CW'(0)) - (pop ? CW'(1) : CW'(0));
            if (drop) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; stale entries are hidden by the empty mask on the outputs
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (push && (k < int'(in_cnt))) begin
                mem_q[wr_ptr_q + AW'(k)] <= in_bus[(LANES-k)*GENE_SZ-1 -: GENE_SZ];
                tag_q[wr_ptr_q + AW'(k)] <= in_eog && (k == int'(in_cnt) - 1);
            end
        end
    end

    assign out_valid = (count_q != '0);
    assign out_gene  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_last  = out_valid ? tag_q[rd_ptr_q] : 1'b0;
    assign in_ready  = (free >= CW'(LANES));
    assign err       = err_q;

`ifdef GENE_SER_CNT_EN
    logic [15:0] gcnt_q, gcnt_d;

    always_comb begin
        gcnt_d = gcnt_q;
        if (clr) begin
            gcnt_d = '0;
        end else if (pop) begin
            if (out_last)                gcnt_d = '0;
            else if (gcnt_q != 16'hFFFF) gcnt_d = gcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gcnt_q <= '0;
        else     gcnt_q <= gcnt_d;
    end

    assign out_gene_cnt = gcnt_q;
`else
    assign out_gene_cnt = '0;
`endif

endmodule

// File: tb/tb_gene_bus_serializer.sv
// Directed bench for gene_bus_serializer: ordering, tags, drop/err rules, wrap, clr and async rst.
module tb_gene_bus_serializer;

    localparam int GENE_SZ = 64;
    localparam int LANES   = 6;
    localparam int DEPTH   = 16;
`ifdef GENE_SER_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic [LANES*GENE_SZ-1:0] in_bus;
    logic [2:0]               in_cnt;
    logic                     in_eog;
    logic                     in_ready;
    logic [GENE_SZ-1:0]       out_gene;
    logic                     out_valid;
    logic                     out_last;
    logic                     out_ready;
    logic                     err;
    logic [15:0]              out_gene_cnt;

    int total = 0;
    int bad   = 0;
    int next_id = 1;
    logic [15:0] cnt_model = '0;
    logic [GENE_SZ:0] exp_q [$];

    gene_bus_serializer #(.GENE_SZ(GENE_SZ), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_bus(in_bus), .in_cnt(in_cnt), .in_eog(in_eog),
        .in_ready(in_ready), .out_gene(out_gene), .out_valid(out_valid), .out_last(out_last),
        .out_ready(out_ready), .err(err), .out_gene_cnt(out_gene_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [GENE_SZ-1:0] gene(input int id);
        return 64'hA5C0_0000_0000_0000 | 64'(id);
    endfunction

    // Presents one batch for a single edge; ok says whether it must be accepted.
    task automatic send(input int n, input bit eog, input bit ok);
        in_bus = '0;
        for (int k = 0; k < LANES; k++)
            if (k < n) in_bus[(LANES-k)*GENE_SZ-1 -: GENE_SZ] = gene(next_id + k);
        in_cnt = 3'(n);
        in_eog = eog;
        if (ok) for (int k = 0; k < n; k++) exp_q.push_back({eog && (k == n-1), gene(next_id + k)});
        next_id += n;
        tick();
        in_cnt = '0;
        in_eog = 1'b0;
        in_bus = '0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        exp_q.delete();
        cnt_model = '0;
    endtask

    task automatic model_pop(input logic last);
        if (last) cnt_model = '0;
        else if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    endtask

    task automatic drain(input string tag);
        logic [GENE_SZ:0] e;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_gene"}, out_gene, e[GENE_SZ-1:0]);
            chk({tag, "_last"}, 64'(out_last), 64'(e[GENE_SZ]));
            chk({tag, "_gcnt"}, 64'(out_gene_cnt), CNT_EN ? 64'(cnt_model) : 64'd0);
            model_pop(e[GENE_SZ]);
            tick();
        end
        chk({tag, "_empty"}, 64'(out_valid), 64'd0);
        chk({tag, "_gene0"}, out_gene, 64'd0);
        chk({tag, "_gcnt_end"}, 64'(out_gene_cnt), CNT_EN ? 64'(cnt_model) : 64'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_bus = '0; in_cnt = '0; in_eog = 1'b0; out_ready = 1'b0;
        #23;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_gene", out_gene, 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_gcnt", 64'(out_gene_cnt), 64'd0);
        rst = 1'b0;
        #1;
        tick();

        // A,B,C as final batch of a genome; head visible right after the push edge
        out_ready = 1'b1;
        send(3, 1'b1, 1'b1);
        chk("t1_lat_valid", 64'(out_valid), 64'd1);
        chk("t1_lat_gene", out_gene, gene(1));
        drain("t1");
        chk("t1_err", 64'(err), 64'd0);

        // 6+6 fills to 12, then 5 must be dropped whole
        do_clr();
        send(6, 1'b0, 1'b1);
        chk("t2_ready6", 64'(in_ready), 64'd1);
        send(6, 1'b0, 1'b1);
        chk("t2_ready12", 64'(in_ready), 64'd0);
        chk("t2_err0", 64'(err), 64'd0);
        send(5, 1'b0, 1'b0);
        chk("t2_err1", 64'(err), 64'd1);
        chk("t2_ready_after", 64'(in_ready), 64'd0);
        drain("t2");
        chk("t2_err_sticky", 64'(err), 64'd1);

        // count 15, push 2 alongside a pop: pre-cycle free=1 so drop, count 14
        do_clr();
        chk("t3_err_clr", 64'(err), 64'd0);
        send(6, 1'b0, 1'b1);
        send(6, 1'b0, 1'b1);
        send(3, 1'b1, 1'b1);
        out_ready = 1'b1;
        chk("t3_head", out_gene, gene(next_id - 15));
        model_pop(exp_q[0][GENE_SZ]);
        void'(exp_q.pop_front());
        send(2, 1'b0, 1'b0);
        chk("t3_err", 64'(err), 64'd1);
        out_ready = 1'b0;
        chk("t3_left", 64'(exp_q.size()), 64'd14);
        drain("t3");

        // wr_ptr walks 0 -> 12 -> 14 -> 4 across the wrap
        do_clr();
        send(6, 1'b0, 1'b1);
        send(6, 1'b1, 1'b1);
        drain("t4a");
        send(2, 1'b0, 1'b1);
        drain("t4b");
        send(6, 1'b1, 1'b1);
        drain("t4c");
        chk("t4_err", 64'(err), 64'd0);

        // illegal in_cnt, then eog with no data
        do_clr();
        send(7, 1'b0, 1'b0);
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_err", 64'(err), 64'd1);
        do_clr();
        send(0, 1'b1, 1'b0);
        chk("t5_eog0_valid", 64'(out_valid), 64'd0);
        chk("t5_eog0_err", 64'(err), 64'd0);
        chk("t5_eog0_ready", 64'(in_ready), 64'd1);

        // clr with queued data, a set err and a nonzero counter; a concurrent push is ignored
        send(5, 1'b0, 1'b1);
        send(7, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_pop(exp_q[0][GENE_SZ]);
            void'(exp_q.pop_front());
            tick();
        end
        chk("t6_gcnt_pre", 64'(out_gene_cnt), CNT_EN ? 64'd2 : 64'd0);
        chk("t6_err_pre", 64'(err), 64'd1);
        in_cnt = 3'd3;
        in_bus = '1;
        do_clr();
        in_cnt = '0;
        in_bus = '0;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_err", 64'(err), 64'd0);
        chk("t6_gcnt", 64'(out_gene_cnt), 64'd0);
        chk("t6_gene", out_gene, 64'd0);
        out_ready = 1'b0;

        // async rst in the middle of popping
        send(4, 1'b1, 1'b1);
        out_ready = 1'b1;
        tick();
        chk("t7_popping", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_valid", 64'(out_valid), 64'd0);
        chk("t7_gene", out_gene, 64'd0);
        chk("t7_last", 64'(out_last), 64'd0);
        chk("t7_gcnt", 64'(out_gene_cnt), 64'd0);
        chk("t7_ready", 64'(in_ready), 64'd1);
        chk("t7_err", 64'(err), 64'd0);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t7_after", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
